mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req  input  2  per-port request; bit 0 = instruction fetch port, bit 1 = data port.
REQ-006 we  input  2  per-port write enable, qualified by req.
REQ-007 addr  input  2*ADDR_W  per-port word address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-008 wdata  input  2*DATA_W  per-port write data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-009 gnt  output  2  one-hot, one-cycle acceptance pulse per port.
REQ-010 rvalid  output  2  one-hot, one-cycle read-data-valid pulse per port.
REQ-011 rdata  output  DATA_W  read data, shared, meaningful only while any rvalid bit is 1.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write strobe, only high with mem_en.
REQ-014 mem_addr  output  ADDR_W  memory word address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, synchronous: valid the cycle after mem_en.

Function
REQ-017 FSM states: IDLE, ISSUE, RESP; ISSUE always lasts exactly one cycle, RESP always lasts exactly one cycle.
REQ-018 Arbitration evaluated in IDLE and in RESP: if any req bit is 1, next state ISSUE with winner latched; else next state IDLE.
REQ-019 Round-robin: single request wins; on simultaneous requests the port not granted last wins; last-winner register updates on every grant.
REQ-020 On entry to ISSUE, winner's addr, we, wdata latched; in ISSUE: gnt[winner]=1, mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values.
REQ-021 In RESP: for a read, rvalid[winner]=1 and rdata=mem_rdata (combinational pass-through); for a write, rvalid stays 0.
REQ-022 Latency: req sampled at edge T -> gnt and mem_en during cycle T+1 -> rvalid during T+2; back-to-back throughput one access per 2 cycles.
REQ-023 Requester holds req, we, addr, wdata stable until it observes gnt, and deasserts req the cycle after gnt unless issuing a new request.
REQ-024 A req bit high in the RESP cycle is treated as a new request (arbitrated per REQ-019).
REQ-025 req dropped before gnt: no access, no gnt, no rvalid for that port.
REQ-026 Outside ISSUE: gnt=0, mem_en=0, mem_we=0; outside RESP: rvalid=0.
REQ-027 At most one gnt bit and at most one rvalid bit high in any cycle.
REQ-028 mem_addr and mem_wdata hold last latched values outside ISSUE.

Reset
REQ-029 rst=0 forces immediately, regardless of clk: state IDLE, gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, last-winner=port 1 (so port 0 wins first tie).
REQ-030 Reset in ISSUE or RESP aborts the transaction: no rvalid produced; a write already strobed may or may not have reached the memory.
REQ-031 First arbitration on the first rising edge with rst=1.

Verification
REQ-032 Single read: memory word 5 = 0x0000_00A7; req=01, addr0=5, we=00 -> gnt=01 next cycle with mem_en=1, mem_addr=5, mem_we=0; following cycle rvalid=01, rdata=0x0000_00A7.
REQ-033 Single write: req=10, we=10, addr1=3, wdata1=0x1234_5678 -> gnt=10, mem_en=1, mem_we=1, mem_addr=3, mem_wdata=0x1234_5678; no rvalid; later port-0 read of address 3 returns 0x1234_5678.
REQ-034 Contention: req=11 held continuously after reset -> grants alternate 01,10,01,10 on ISSUE cycles spaced 2 cycles apart; rvalid follows each grant by one cycle.
REQ-035 Back-to-back: port 0 reads addresses 0,1,2 with a new req each RESP cycle -> gnt every 2 cycles, rdata returns words 0,1,2 in order.
REQ-036 Reset mid-operation: assert rst=0 asynchronously during ISSUE of a read -> all outputs 0 without waiting for clk, no rvalid afterwards; after release, req=11 grants port 0 first.
REQ-037 Checker on all scenarios: gnt and rvalid one-hot-or-zero; mem_we never 1 while mem_en is 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous memory.
// One access per two cycles: ISSUE drives the memory, RESP returns read data.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_last;
  logic                r_win;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_arb;
  logic                w_pick;
  logic                w_we_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [DATA_W-1:0]   w_wdata_sel;

  // A lone request wins outright; on a tie the port not granted last wins.
  always_comb begin
    w_pick = (req == 2'b11) ? ~r_last : req[1];
  end

  always_comb begin
    w_we_sel    = w_pick ? we[1] : we[0];
    w_addr_sel  = w_pick ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
    w_wdata_sel = w_pick ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
  end

  always_comb begin
    w_state_d = r_state;
    w_arb     = 1'b0;
    case (r_state)
      StIdle, StResp: begin
        if (|req) begin
          w_state_d = StIssue;
          w_arb     = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      StIssue: w_state_d = StResp;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_arb) begin
        r_win   <= w_pick;
        r_last  <= w_pick;
        r_we    <= w_we_sel;
        r_addr  <= w_addr_sel;
        r_wdata <= w_wdata_sel;
      end
    end
  end

  // Outputs decode from reset-cleared state, so reset clears them without a clock.
  always_comb begin
    gnt    = 2'b00;
    rvalid = 2'b00;
    mem_en = 1'b0;
    mem_we = 1'b0;
    if (r_state == StIssue) begin
      gnt[r_win] = 1'b1;
      mem_en     = 1'b1;
      mem_we     = r_we;
    end
    if ((r_state == StResp) && !r_we) begin
      rvalid[r_win] = 1'b1;
    end
  end

  assign rdata     = mem_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Advance one cycle, then check the per-cycle invariants.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot0(gnt)) begin errors++; $display("FAIL inv_gnt got %b required onehot0", gnt); end
    checks++;
    if (!$onehot0(rvalid)) begin
      errors++; $display("FAIL inv_rvalid got %b required onehot0", rvalid);
    end
    checks++;
    if (mem_we && !mem_en) begin errors++; $display("FAIL inv_we got mem_we=1 with mem_en=0"); end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    #3;
    checks++;
    if ({gnt, rvalid, mem_en, mem_we} !== 6'b0) begin
      errors++; $display("FAIL rst_ctrl got %b required 000000", {gnt, rvalid, mem_en, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 40'h0) begin
      errors++; $display("FAIL rst_data got %h required 0", {mem_addr, mem_wdata});
    end
    @(negedge clk) rst = 1'b1;
    step();
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL idle_gnt got %b required 00", gnt); end
  endtask

  task automatic test_single_read();
    req = 2'b01; we = 2'b00; addr[7:0] = 8'd5;
    step();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt got %b required 01", gnt); end
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'd5}) begin
      errors++; $display("FAIL rd_mem got %b %b %h required 1 0 05", mem_en, mem_we, mem_addr);
    end
    req = 2'b00;
    step();
    checks++;
    if (rvalid !== 2'b01) begin errors++; $display("FAIL rd_rvalid got %b required 01", rvalid); end
    checks++;
    if (rdata !== 32'h0000_00A7) begin
      errors++; $display("FAIL rd_data got %h required 000000a7", rdata);
    end
    step();
    checks++;
    if (rvalid !== 2'b00) begin errors++; $display("FAIL rd_done got %b required 00", rvalid); end
  endtask

  task automatic test_single_write();
    req = 2'b10; we = 2'b10; addr[15:8] = 8'd3; wdata[63:32] = 32'h1234_5678;
    step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL wr_gnt got %b required 10", gnt); end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'd3, 32'h1234_5678}) begin
      errors++;
      $display("FAIL wr_mem got %b %b %h %h required 1 1 03 12345678",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    req = 2'b00; we = 2'b00;
    step();
    checks++;
    if (rvalid !== 2'b00) begin errors++; $display("FAIL wr_rvalid got %b required 00", rvalid); end
    checks++;
    if ({mem_en, mem_addr, mem_wdata} !== {1'b0, 8'd3, 32'h1234_5678}) begin
      errors++; $display("FAIL wr_hold got %b %h %h required 0 03 12345678",
                         mem_en, mem_addr, mem_wdata);
    end
    step();
    req = 2'b01; addr[7:0] = 8'd3;
    step();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL wr_rb_gnt got %b required 01", gnt); end
    req = 2'b00;
    step();
    checks++;
    if ({rvalid, rdata} !== {2'b01, 32'h1234_5678}) begin
      errors++; $display("FAIL wr_rb_data got %b %h required 01 12345678", rvalid, rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_d [4] = '{32'hAAAA_000A, 32'hBBBB_000B, 32'hAAAA_000A, 32'hBBBB_000B};
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    req = 2'b11; we = 2'b00; addr = {8'd11, 8'd10};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (gnt !== exp_g[i]) begin
        errors++; $display("FAIL cont_gnt%0d got %b required %b", i, gnt, exp_g[i]);
      end
      step();
      checks++;
      if ({rvalid, rdata} !== {exp_g[i], exp_d[i]}) begin
        errors++;
        $display("FAIL cont_rsp%0d got %b %h required %b %h", i, rvalid, rdata, exp_g[i], exp_d[i]);
      end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};
    req = 2'b01; we = 2'b00; addr[7:0] = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt, mem_addr} !== {2'b01, 8'(i)}) begin
        errors++; $display("FAIL b2b_gnt%0d got %b %h required 01 %h", i, gnt, mem_addr, 8'(i));
      end
      if (i < 2) addr[7:0] = 8'(i + 1);
      else       req = 2'b00;
      step();
      checks++;
      if ({gnt, rvalid, rdata} !== {2'b00, 2'b01, words[i]}) begin
        errors++;
        $display("FAIL b2b_rsp%0d got %b %b %h required 00 01 %h", i, gnt, rvalid, rdata, words[i]);
      end
    end
    step();
  endtask

  task automatic test_reset_midop();
    req = 2'b01; we = 2'b00; addr[7:0] = 8'd5;
    step();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL mid_gnt got %b required 01", gnt); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, rvalid, mem_en, mem_we, mem_addr} !== 14'h0) begin
      errors++; $display("FAIL mid_async got %b %b %b %b %h required all zero",
                         gnt, rvalid, mem_en, mem_we, mem_addr);
    end
    req = 2'b00;
    step();
    checks++;
    if (rvalid !== 2'b00) begin errors++; $display("FAIL mid_norv got %b required 00", rvalid); end
    @(negedge clk);
    req = 2'b11; addr = {8'd2, 8'd1}; rst = 1'b1;
    step();
    checks++;
    if ({gnt, mem_addr} !== {2'b01, 8'd1}) begin
      errors++; $display("FAIL mid_first got %b %h required 01 01", gnt, mem_addr);
    end
    req = 2'b00;
    step();
    checks++;
    if ({rvalid, rdata} !== {2'b01, 32'h2222_0001}) begin
      errors++; $display("FAIL mid_after got %b %h required 01 22220001", rvalid, rdata);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0]  = 32'h1111_0000;
    mem[1]  = 32'h2222_0001;
    mem[2]  = 32'h3333_0002;
    mem[5]  = 32'h0000_00A7;
    mem[10] = 32'hAAAA_000A;
    mem[11] = 32'hBBBB_000B;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
